// File: rtl/padd_serial_ctrl_pkg.sv
//----------------------------------------------------------------------------
// padd_serial_ctrl_pkg
// Shared types and constants for the serial sub-word adder.
//   state_t   : controller states (IDLE, RUN, DONE)
//   LANE_W    : width of one signed lane
//   NUM_LANES : number of lanes in a 16-bit word
//   SAT_POS   : lane value written on positive overflow when saturating
//   SAT_NEG   : lane value written on negative overflow when saturating
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package padd_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LANE_W    = 4;
  localparam int NUM_LANES = 4;

  localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

endpackage

`default_nettype wire

// File: rtl/padd_lane4.sv
//----------------------------------------------------------------------------
// padd_lane4
// Combinational signed 4-bit lane adder with overflow detection.
// Optional build macro: PADD_SAT_EN -- when defined, an overflowing lane
// is clamped to SAT_POS / SAT_NEG instead of wrapping.
// Ports:
//   a, b  : signed 4-bit operands
//   res   : 4-bit lane result (wrapped or saturated)
//   ovfl  : signed overflow of a + b
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module padd_lane4
  import padd_serial_ctrl_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] res,
  output logic              ovfl
);

  logic [LANE_W-1:0] raw;

  assign raw = a + b;

  // Overflow: operands share a sign and the result's sign differs from it.
  assign ovfl = (a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);

`ifdef PADD_SAT_EN
  // Overflow direction follows the common operand sign.
  assign res = ovfl ? (a[LANE_W-1] ? SAT_NEG : SAT_POS) : raw;
`else
  assign res = raw;
`endif

endmodule

`default_nettype wire

// File: rtl/padd_serial_ctrl.sv
//----------------------------------------------------------------------------
// padd_serial_ctrl
// Serial 4x4-bit signed sub-word adder. One shared padd_lane4 instance
// processes one lane per clock; lanes never exchange carries.
// Optional build macro: PADD_SAT_EN (lane saturation, see padd_lane4).
// Parameters:
//   HOLD_DONE : 0 = done is a one-cycle pulse, 1 = done held until next start
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : operation request
//   a, b      : operands, lane i = bits [4i+3:4i]
//   busy      : high while lanes are being processed
//   done      : result valid
//   sum       : lane-wise sum register
//   lane_ovfl : per-lane overflow flags
//   error     : OR of lane_ovfl
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module padd_serial_ctrl
  import padd_serial_ctrl_pkg::*;
#(
  parameter bit HOLD_DONE = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LANE_W*NUM_LANES-1:0] a,
  input  logic [LANE_W*NUM_LANES-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [LANE_W*NUM_LANES-1:0] sum,
  output logic [NUM_LANES-1:0]        lane_ovfl,
  output logic                        error
);

  state_t                        state;
  state_t                        state_nxt;
  logic [1:0]                    lane_idx;
  logic [LANE_W*NUM_LANES-1:0]   a_q;
  logic [LANE_W*NUM_LANES-1:0]   b_q;
  logic [LANE_W-1:0]             lane_a;
  logic [LANE_W-1:0]             lane_b;
  logic [LANE_W-1:0]             lane_res;
  logic                          lane_of;
  logic                          accept;

  // Start is only honoured outside RUN so the latched operands stay stable.
  assign accept = start && (state != RUN);

  assign lane_a = a_q[{lane_idx, 2'b00} +: LANE_W];
  assign lane_b = b_q[{lane_idx, 2'b00} +: LANE_W];

  padd_lane4 u_lane (
    .a    (lane_a),
    .b    (lane_b),
    .res  (lane_res),
    .ovfl (lane_of)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (lane_idx == 2'd3) state_nxt = DONE;
      DONE: begin
        if (start)          state_nxt = RUN;
        else if (!HOLD_DONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lane_idx  <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      lane_ovfl <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q       <= a;
        b_q       <= b;
        sum       <= '0;
        lane_ovfl <= '0;
        lane_idx  <= 2'd0;
      end else if (state == RUN) begin
        sum[{lane_idx, 2'b00} +: LANE_W] <= lane_res;
        lane_ovfl[lane_idx]              <= lane_of;
        lane_idx                         <= lane_idx + 2'd1;
      end
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign error = |lane_ovfl;

endmodule

`default_nettype wire

// File: tb/tb_padd_serial_ctrl.sv
//----------------------------------------------------------------------------
// tb_padd_serial_ctrl
// Self-checking bench for padd_serial_ctrl (HOLD_DONE = 0). Honours the
// PADD_SAT_EN build macro when forming expected sums.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_padd_serial_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic [3:0]  lane_ovfl;
  logic        error;

  int total = 0;
  int bad   = 0;

  padd_serial_ctrl #(.HOLD_DONE(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .lane_ovfl (lane_ovfl),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_sum;
    logic [3:0]  exp_ovfl;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives start for exactly one edge (E0); returns at the negedge after E0.
  task automatic start_op(input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    start_op(v.a, v.b);
    for (int k = 0; k < 4; k++) begin
      $sformat(nm, "v%0d_busy%0d", idx, k);
      check(nm, {31'd0, busy}, 32'd1);
      $sformat(nm, "v%0d_nodone%0d", idx, k);
      check(nm, {31'd0, done}, 32'd0);
      if (k < 3) @(negedge clk);
    end
    @(negedge clk);
    $sformat(nm, "v%0d_done", idx);
    check(nm, {31'd0, done}, 32'd1);
    $sformat(nm, "v%0d_busy_off", idx);
    check(nm, {31'd0, busy}, 32'd0);
    $sformat(nm, "v%0d_sum", idx);
    check(nm, {16'd0, sum}, {16'd0, v.exp_sum});
    $sformat(nm, "v%0d_ovfl", idx);
    check(nm, {28'd0, lane_ovfl}, {28'd0, v.exp_ovfl});
    $sformat(nm, "v%0d_error", idx);
    check(nm, {31'd0, error}, {31'd0, |v.exp_ovfl});
    @(negedge clk);
    $sformat(nm, "v%0d_done_pulse", idx);
    check(nm, {31'd0, done}, 32'd0);
    $sformat(nm, "v%0d_sum_hold", idx);
    check(nm, {16'd0, sum}, {16'd0, v.exp_sum});
  endtask

  vec_t vecs [6];

  initial begin
    int done_cnt;
    int cyc;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

`ifdef PADD_SAT_EN
    vecs[0] = '{16'h1234, 16'h1111, 16'h2345, 4'h0};
    vecs[1] = '{16'h7777, 16'h1111, 16'h7777, 4'hF};
    vecs[2] = '{16'h8000, 16'h8000, 16'h8000, 4'h8};
    vecs[3] = '{16'hFFFF, 16'h0001, 16'hFFF0, 4'h0};
    vecs[4] = '{16'h4321, 16'h4444, 16'h7765, 4'h8};
    vecs[5] = '{16'h8888, 16'h8888, 16'h8888, 4'hF};
`else
    vecs[0] = '{16'h1234, 16'h1111, 16'h2345, 4'h0};
    vecs[1] = '{16'h7777, 16'h1111, 16'h8888, 4'hF};
    vecs[2] = '{16'h8000, 16'h8000, 16'h0000, 4'h8};
    vecs[3] = '{16'hFFFF, 16'h0001, 16'hFFF0, 4'h0};
    vecs[4] = '{16'h4321, 16'h4444, 16'h8765, 4'h8};
    vecs[5] = '{16'h8888, 16'h8888, 16'h0000, 4'hF};
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_done",  {31'd0, done},      32'd0);
    check("rst_sum",   {16'd0, sum},       32'd0);
    check("rst_ovfl",  {28'd0, lane_ovfl}, 32'd0);
    check("rst_error", {31'd0, error},     32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Start during RUN is ignored
    start_op(16'h0001, 16'h0001);
    @(negedge clk);                       // after E1
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    @(negedge clk);                       // after E2 (start sampled in RUN)
    start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("ign_done_cnt", done_cnt, 32'd1);
    check("ign_sum", {16'd0, sum}, 32'h0002);
    check("ign_ovfl", {28'd0, lane_ovfl}, 32'd0);

    // Reset between E2 and E3
    start_op(16'h7777, 16'h1111);
    @(negedge clk);                       // after E1
    @(negedge clk);                       // after E2
    check("pre_rst_sum_nonzero", {31'd0, sum != 16'd0}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy",  {31'd0, busy},      32'd0);
    check("mrst_done",  {31'd0, done},      32'd0);
    check("mrst_sum",   {16'd0, sum},       32'd0);
    check("mrst_ovfl",  {28'd0, lane_ovfl}, 32'd0);
    check("mrst_error", {31'd0, error},     32'd0);
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mrst_no_done", done_cnt, 32'd0);
    // Release reset with start already asserted: first edge accepts it.
    rst_n = 1'b1;
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 3; k++) @(negedge clk);
    @(negedge clk);
    check("post_rst_done", {31'd0, done}, 32'd1);
    check("post_rst_sum", {16'd0, sum}, 32'h2345);

    // Back-to-back: start accepted in the DONE cycle
    @(negedge clk);
    start_op(16'h1234, 16'h1111);
    cyc = 0;
    while (!done && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_sum", {16'd0, sum}, 32'h2345);
    start = 1'b1;
    a     = 16'h2222;
    b     = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_next", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_gap", cyc, 32'd5);
    check("b2b_second_sum", {16'd0, sum}, 32'h3333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/padd_serial_ctrl.md
PADD_SERIAL_CTRL -- requirements
Module: padd_serial_ctrl

Interface
REQ-001 The block SHALL have parameter HOLD_DONE, default 0, meaning 0 = done is a one-cycle pulse and 1 = done is held until the next accepted start.
REQ-002 The block SHALL have port clk  input  1  system clock; the block has one clock and all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  operation request, sampled on the rising edge.
REQ-005 The block SHALL have ports a, b  input  16  operands, treated as four signed 4-bit lanes; lane i is bits [4i+3:4i].
REQ-006 The block SHALL have port busy  output  1  high while lanes are being processed.
REQ-007 The block SHALL have port done  output  1  result-valid indication.
REQ-008 The block SHALL have port sum  output  16  lane-wise sum register.
REQ-009 The block SHALL have port lane_ovfl  output  4  per-lane overflow flags.
REQ-010 The block SHALL have port error  output  1  OR of lane_ovfl.

Function
REQ-011 The block SHALL compute the 16-bit parallel sub-word sum serially, using one shared 4-bit adder instance, one lane per cycle.
REQ-012 The state machine SHALL have the states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, a sampled start SHALL latch a and b, clear sum and lane_ovfl to 0, set the lane index to 0 and enter RUN.
REQ-014 In RUN, each edge SHALL process the lane given by the lane index, write its 4-bit result into sum, write its lane_ovfl bit and increment the 2-bit index.
REQ-015 RUN SHALL advance to DONE after the edge that processes lane 3.
REQ-016 Latency: start sampled at edge E0; lanes 0..3 are processed at edges E1..E4; done=1 and results are valid after E4.
REQ-017 With HOLD_DONE=0, DONE SHALL return to IDLE at the next edge (done is high for exactly one cycle).
REQ-018 With HOLD_DONE=1, the block SHALL remain in DONE until a start is accepted.
REQ-019 busy SHALL equal (state==RUN).
REQ-020 done SHALL equal (state==DONE).
REQ-021 A start while in RUN SHALL be ignored; the latched operands SHALL be unaffected.
REQ-022 A start sampled in the DONE cycle SHALL be accepted, giving back-to-back operations with no IDLE gap.
REQ-023 Lane overflow SHALL be flagged when the operand sign bits are equal and the sign of the 4-bit result differs from them.
REQ-024 Carry SHALL NOT propagate between lanes.
REQ-025 sum, lane_ovfl and error SHALL hold their last values in IDLE and DONE until the next accepted start.
REQ-026 error SHALL be combinational from the lane_ovfl register.

Reset
REQ-027 While rst_n=0, the block SHALL be in IDLE with the lane index, sum, lane_ovfl, error, busy and done all 0, and the latched operands at 0.
REQ-028 Reset mid-RUN SHALL abandon the operation immediately and produce no done.
REQ-029 The first edge after rst_n rises SHALL be able to accept a start.

Configuration
REQ-030 The macro PADD_SAT_EN SHALL control lane saturation.
REQ-031 With PADD_SAT_EN defined, an overflowing lane SHALL write 4'h7 on positive overflow and 4'h8 on negative overflow.
REQ-032 Without PADD_SAT_EN, an overflowing lane SHALL write the wrapped 4-bit result.
REQ-033 lane_ovfl and error SHALL be identical in both builds.

Structure
REQ-034 The shared package SHALL hold the state enum (IDLE, RUN, DONE), LANE_W=4, NUM_LANES=4, SAT_POS=4'h7 and SAT_NEG=4'h8.
REQ-035 The block SHALL contain one sub-module, padd_lane4: a combinational 4-bit signed adder producing the result and the overflow, with optional saturation.
REQ-036 The lane multiplexing, state machine and registers SHALL reside in padd_serial_ctrl.

Verification
REQ-037 Bench SHALL drive a=16'h1234, b=16'h1111, start for one cycle -> busy for 4 cycles, done after E4, sum=16'h2345, lane_ovfl=4'h0, error=0.
REQ-038 Bench SHALL drive a=16'h7777, b=16'h1111 -> lane_ovfl=4'hF, error=1; sum=16'h7777 with PADD_SAT_EN, 16'h8888 without.
REQ-039 Bench SHALL drive a=16'h8000, b=16'h8000 -> lane_ovfl=4'b1000; sum=16'h8000 with PADD_SAT_EN, 16'h0000 without.
REQ-040 Bench SHALL drive start with a=16'h0001, b=16'h0001, then start with a=16'hFFFF, b=16'hFFFF at E2 -> the second start is ignored, sum=16'h0002, done once.
REQ-041 Bench SHALL assert rst_n=0 between E2 and E3 of an operation -> all outputs read 0 immediately, no done; after release, a fresh start with a=16'h1234, b=16'h1111 completes with sum=16'h2345.
REQ-042 Bench SHALL, with HOLD_DONE=0, assert start in the DONE cycle with new operands -> busy the next cycle, second done exactly 5 cycles after the first.
